// File: rtl/vmicro16_core_ctrl.sv
// ----------------------------------------------------------------------------
// vmicro16_core_ctrl
//
// Multi-cycle sequencer for the vmicro16 core datapath. Owns the PC, the
// instruction register and the control state machine, and steps every
// instruction through FETCH -> FWAIT -> EXEC -> [MEM -> [MWAIT]] -> [WB].
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   imem_addr/rdata     instruction BRAM (address = pc, 1-cycle read latency)
//   instr               latched instruction, drives the external decoder
//   dec_*               decoder flags for the latched instruction
//   br_taken/br_target  branch resolution from the datapath
//   alu_c               ALU result (captured in EXEC)
//   rd_data             register-file read of rd (store data)
//   mem_*               scratch-memory request/grant port
//   reg_we/ws/wd        register-file write port
//   pc, halted, state   status / debug
// ----------------------------------------------------------------------------
module vmicro16_core_ctrl #(
    parameter int                  PC_WIDTH     = 16,
    parameter int                  DATA_WIDTH   = 16,
    parameter int                  REG_SEL_BITS = 3,
    parameter logic [PC_WIDTH-1:0] RESET_PC     = '0
) (
    input  logic                    clk,
    input  logic                    reset,

    output logic [PC_WIDTH-1:0]     imem_addr,
    input  logic [DATA_WIDTH-1:0]   imem_rdata,
    output logic [DATA_WIDTH-1:0]   instr,

    input  logic                    dec_has_we,
    input  logic                    dec_has_mem,
    input  logic                    dec_has_mem_we,
    input  logic                    dec_has_br,
    input  logic                    dec_halt,
    input  logic                    br_taken,
    input  logic [PC_WIDTH-1:0]     br_target,
    input  logic [DATA_WIDTH-1:0]   alu_c,
    input  logic [DATA_WIDTH-1:0]   rd_data,

    output logic                    mem_req,
    output logic                    mem_we,
    output logic [DATA_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_wdata,
    input  logic                    mem_gnt,
    input  logic [DATA_WIDTH-1:0]   mem_rdata,

    output logic                    reg_we,
    output logic [REG_SEL_BITS-1:0] reg_ws,
    output logic [DATA_WIDTH-1:0]   reg_wd,

    output logic [PC_WIDTH-1:0]     pc,
    output logic                    halted,
    output logic [2:0]              state
);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0,
        S_FWAIT = 3'd1,
        S_EXEC  = 3'd2,
        S_MEM   = 3'd3,
        S_MWAIT = 3'd4,
        S_WB    = 3'd5,
        S_HALT  = 3'd6
    } state_t;

    state_t                  r_state;
    logic [PC_WIDTH-1:0]     r_pc;
    logic [DATA_WIDTH-1:0]   r_instr;
    logic [DATA_WIDTH-1:0]   r_result;
    logic [DATA_WIDTH-1:0]   r_load;
    logic                    r_is_load;
    logic                    r_mem_req;
    logic                    r_mem_we;
    logic [DATA_WIDTH-1:0]   r_mem_wdata;
    logic                    r_reg_we;
    logic                    r_halted;

    // NOTE: every register here is updated with <= so all of them sample the
    // pre-edge values of each other; a blocking = would let later statements
    // see this cycle's new state and silently reorder the pipeline.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_FETCH;
            r_pc        <= RESET_PC;
            r_instr     <= '0;
            r_result    <= '0;
            r_load      <= '0;
            r_is_load   <= 1'b0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_wdata <= '0;
            r_reg_we    <= 1'b0;
            r_halted    <= 1'b0;
        end else begin
            case (r_state)
                // imem_addr already shows pc; the BRAM registers it this edge.
                S_FETCH: r_state <= S_FWAIT;

                S_FWAIT: begin
                    r_instr <= imem_rdata;
                    r_state <= S_EXEC;
                end

                S_EXEC: begin
                    r_result <= alu_c;
                    if (dec_halt) begin
                        // PC stays on the HALT itself.
                        r_state  <= S_HALT;
                        r_halted <= 1'b1;
                    end else begin
                        // Natural overflow of the add gives the modulo wrap.
                        r_pc      <= (dec_has_br && br_taken) ? br_target
                                                              : r_pc + PC_WIDTH'(1);
                        r_is_load <= dec_has_mem && !dec_has_mem_we;
                        if (dec_has_mem) begin
                            // Request fields are captured once here so they
                            // stay stable however long the grant takes.
                            r_state     <= S_MEM;
                            r_mem_req   <= 1'b1;
                            r_mem_we    <= dec_has_mem_we;
                            r_mem_wdata <= rd_data;
                        end else if (dec_has_we) begin
                            r_state  <= S_WB;
                            r_reg_we <= 1'b1;
                        end else begin
                            r_state <= S_FETCH;
                        end
                    end
                end

                S_MEM: begin
                    if (mem_gnt) begin
                        r_mem_req <= 1'b0;
                        r_mem_we  <= 1'b0;
                        r_state   <= r_is_load ? S_MWAIT : S_FETCH;
                    end
                end

                S_MWAIT: begin
                    r_load   <= mem_rdata;
                    r_reg_we <= 1'b1;
                    r_state  <= S_WB;
                end

                S_WB: begin
                    r_reg_we <= 1'b0;
                    r_state  <= S_FETCH;
                end

                S_HALT: r_state <= S_HALT;

                default: r_state <= S_FETCH;
            endcase
        end
    end

    assign imem_addr = r_pc;
    assign pc        = r_pc;
    assign instr     = r_instr;
    assign state     = r_state;
    assign halted    = r_halted;

    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_result;
    assign mem_wdata = r_mem_wdata;

    assign reg_we    = r_reg_we;
    assign reg_ws    = r_instr[8 +: REG_SEL_BITS];
    assign reg_wd    = r_is_load ? r_load : r_result;

endmodule

// File: tb/tb_vmicro16_core_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vmicro16_core_ctrl
//
// Self-checking bench for vmicro16_core_ctrl. The bench plays the decoder,
// ALU, instruction BRAM and scratch-memory arbiter, and judges each
// instruction by its visible effects (cycle count, register write, memory
// request, next PC) against expectations derived from the instruction kind.
// ----------------------------------------------------------------------------
module tb_vmicro16_core_ctrl;

    localparam int PW = 16;
    localparam int DW = 16;
    localparam int RW = 3;

    localparam logic [2:0] ST_FETCH = 3'd0;
    localparam logic [2:0] ST_EXEC  = 3'd2;
    localparam logic [2:0] ST_MEM   = 3'd3;
    localparam logic [2:0] ST_HALT  = 3'd6;

    typedef enum int {K_NOP, K_BR, K_ALU, K_SW, K_LW, K_HALT} kind_t;

    typedef struct {
        kind_t         kind;
        logic          br_taken;
        logic [PW-1:0] br_target;
        logic [DW-1:0] alu;
        logic [DW-1:0] rd_data;
        logic [DW-1:0] load;
        logic [RW-1:0] rd;
        int            waits;
    } stim_t;

    typedef struct {
        int            cycles;
        int            we_n;
        logic [RW-1:0] ws;
        logic [DW-1:0] wd;
        int            we_cycle;
        int            mem_n;
        logic          mem_we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          unstable;
        logic [PW-1:0] pc;
        logic [DW-1:0] instr;
        logic          timeout;
    } obs_t;

    typedef struct {
        stim_t         s;
        int            cycles;
        int            we;
        logic [DW-1:0] wd;
        int            mem_n;
        logic          mem_we;
        logic [DW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [PW-1:0] pc;
    } vec_t;

    logic          clk;
    logic          reset;
    logic [PW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic [DW-1:0] instr;
    logic          dec_has_we, dec_has_mem, dec_has_mem_we, dec_has_br, dec_halt;
    logic          br_taken;
    logic [PW-1:0] br_target;
    logic [DW-1:0] alu_c;
    logic [DW-1:0] rd_data;
    logic          mem_req, mem_we;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mem_gnt;
    logic [DW-1:0] mem_rdata;
    logic          reg_we;
    logic [RW-1:0] reg_ws;
    logic [DW-1:0] reg_wd;
    logic [PW-1:0] pc;
    logic          halted;
    logic [2:0]    state;

    int checks = 0;
    int errors = 0;

    vmicro16_core_ctrl #(
        .PC_WIDTH    (PW),
        .DATA_WIDTH  (DW),
        .REG_SEL_BITS(RW),
        .RESET_PC    (16'h0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .imem_addr     (imem_addr),
        .imem_rdata    (imem_rdata),
        .instr         (instr),
        .dec_has_we    (dec_has_we),
        .dec_has_mem   (dec_has_mem),
        .dec_has_mem_we(dec_has_mem_we),
        .dec_has_br    (dec_has_br),
        .dec_halt      (dec_halt),
        .br_taken      (br_taken),
        .br_target     (br_target),
        .alu_c         (alu_c),
        .rd_data       (rd_data),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wdata     (mem_wdata),
        .mem_gnt       (mem_gnt),
        .mem_rdata     (mem_rdata),
        .reg_we        (reg_we),
        .reg_ws        (reg_ws),
        .reg_wd        (reg_wd),
        .pc            (pc),
        .halted        (halted),
        .state         (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction BRAM: one-cycle synchronous read.
    logic [DW-1:0] imem [0:255];
    always @(posedge clk) imem_rdata <= imem[imem_addr[7:0]];

    initial begin
        #2ms;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic stim_t st(kind_t k, logic tk, logic [PW-1:0] tgt, logic [DW-1:0] alu,
                                 logic [DW-1:0] rdd, logic [DW-1:0] ld, logic [RW-1:0] rd, int w);
        stim_t s;
        s.kind = k; s.br_taken = tk; s.br_target = tgt; s.alu = alu;
        s.rd_data = rdd; s.load = ld; s.rd = rd; s.waits = w;
        return s;
    endfunction

    function automatic logic [DW-1:0] mkword(logic [RW-1:0] rd);
        logic [DW-1:0] w;
        w = 16'($urandom);
        w[10:8] = rd;
        return w;
    endfunction

    // Reference model: effects of one instruction from its kind alone.
    function automatic obs_t model(stim_t s, logic [PW-1:0] pc_in, logic [DW-1:0] word);
        obs_t e;
        e = '{default: 0};
        e.instr = word;
        e.pc    = (s.kind == K_BR && s.br_taken) ? s.br_target : pc_in + 16'd1;
        case (s.kind)
            K_NOP, K_BR: e.cycles = 3;
            K_ALU: begin e.cycles = 4; e.we_n = 1; e.wd = s.alu; end
            K_SW: begin
                e.cycles = 4 + s.waits; e.mem_n = s.waits + 1;
                e.mem_we = 1'b1; e.addr = s.alu; e.wdata = s.rd_data;
            end
            K_LW: begin
                e.cycles = 6 + s.waits; e.mem_n = s.waits + 1;
                e.addr = s.alu; e.wdata = s.rd_data; e.we_n = 1; e.wd = s.load;
            end
            K_HALT: begin e.cycles = 3; e.pc = pc_in; end
            default: e.cycles = 0;
        endcase
        if (e.we_n != 0) begin
            e.ws = s.rd;
            e.we_cycle = e.cycles;
        end
        return e;
    endfunction

    task automatic set_dec(input kind_t k);
        dec_has_br     = (k == K_BR);
        dec_has_we     = (k == K_ALU) || (k == K_LW);
        dec_has_mem    = (k == K_SW) || (k == K_LW);
        dec_has_mem_we = (k == K_SW);
        dec_halt       = (k == K_HALT);
    endtask

    // Runs one instruction starting at a negedge in FETCH; returns at the
    // negedge where the next FETCH (or HALT) is visible.
    task automatic run_instr(input stim_t s, input logic [DW-1:0] word, output obs_t o);
        int   waits_left;
        int   c;
        logic granted_read;
        o = '{default: 0};
        imem[pc[7:0]] = word;
        set_dec(s.kind);
        br_taken     = s.br_taken;
        rd_data      = s.rd_data;
        waits_left   = s.waits;
        granted_read = 1'b0;
        c = 0;
        while (1) begin
            c++;
            o.cycles = c;
            // ALU/branch values are only meaningful while in EXEC.
            alu_c     = (state == ST_EXEC) ? s.alu       : 16'($urandom);
            br_target = (state == ST_EXEC) ? s.br_target : 16'($urandom);
            mem_rdata = granted_read ? s.load : 16'($urandom);
            granted_read = 1'b0;
            if (state == ST_EXEC) o.instr = instr;
            if (mem_req) begin
                if (o.mem_n == 0) begin
                    o.mem_we = mem_we; o.addr = mem_addr; o.wdata = mem_wdata;
                end else if (mem_we !== o.mem_we || mem_addr !== o.addr || mem_wdata !== o.wdata) begin
                    o.unstable = 1'b1;
                end
                o.mem_n++;
                if (waits_left > 0) begin
                    mem_gnt = 1'b0;
                    waits_left--;
                end else begin
                    mem_gnt = 1'b1;
                    granted_read = !mem_we;
                end
            end else begin
                mem_gnt = 1'($urandom);
            end
            if (reg_we) begin
                o.we_n++; o.ws = reg_ws; o.wd = reg_wd; o.we_cycle = c;
            end
            @(negedge clk);
            if (state == ST_FETCH || state == ST_HALT) break;
            if (c >= 64) begin
                o.timeout = 1'b1;
                break;
            end
        end
        o.pc = pc;
        set_dec(K_NOP);
        mem_gnt = 1'b0;
    endtask

    task automatic cmp_obs(input string tag, input obs_t o, input obs_t e);
        check({tag, ".timeout"},  32'(o.timeout),  32'(e.timeout));
        check({tag, ".cycles"},   o.cycles,        e.cycles);
        check({tag, ".instr"},    32'(o.instr),    32'(e.instr));
        check({tag, ".we_n"},     o.we_n,          e.we_n);
        check({tag, ".ws"},       32'(o.ws),       32'(e.ws));
        check({tag, ".wd"},       32'(o.wd),       32'(e.wd));
        check({tag, ".we_cycle"}, o.we_cycle,      e.we_cycle);
        check({tag, ".mem_n"},    o.mem_n,         e.mem_n);
        check({tag, ".mem_we"},   32'(o.mem_we),   32'(e.mem_we));
        check({tag, ".addr"},     32'(o.addr),     32'(e.addr));
        check({tag, ".wdata"},    32'(o.wdata),    32'(e.wdata));
        check({tag, ".unstable"}, 32'(o.unstable), 32'(e.unstable));
        check({tag, ".pc"},       32'(o.pc),       32'(e.pc));
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        set_dec(K_NOP);
        mem_gnt = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        vec_t          vecs [10];
        stim_t         s;
        obs_t          o, e;
        logic [DW-1:0] word;
        logic [PW-1:0] m_pc;
        int            n, bad;

        // Hand-computed vectors, run back to back from reset (pc = 0).
        //           kind   tk  target    alu       rd_data   load     rd   w   cyc we wd       mem mw addr      wdata     pc
        vecs[0] = '{st(K_ALU, 0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 3'd1, 0), 4, 1, 16'h0005, 0, 0, 16'h0000, 16'h0000, 16'h0001};
        vecs[1] = '{st(K_SW,  0, 16'h0000, 16'h0010, 16'hBEEF, 16'h0000, 3'd3, 3), 7, 0, 16'h0000, 4, 1, 16'h0010, 16'hBEEF, 16'h0002};
        vecs[2] = '{st(K_LW,  0, 16'h0000, 16'h0020, 16'h5555, 16'h1234, 3'd2, 0), 6, 1, 16'h1234, 1, 0, 16'h0020, 16'h5555, 16'h0003};
        vecs[3] = '{st(K_BR,  1, 16'h0030, 16'h9999, 16'h0000, 16'h0000, 3'd0, 0), 3, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0030};
        vecs[4] = '{st(K_BR,  0, 16'h0077, 16'h9999, 16'h0000, 16'h0000, 3'd0, 0), 3, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0031};
        vecs[5] = '{st(K_LW,  0, 16'h0000, 16'h0042, 16'h0000, 16'hA5A5, 3'd7, 2), 8, 1, 16'hA5A5, 3, 0, 16'h0042, 16'h0000, 16'h0032};
        vecs[6] = '{st(K_ALU, 0, 16'h0000, 16'hFFFF, 16'h0000, 16'h0000, 3'd0, 5), 4, 1, 16'hFFFF, 0, 0, 16'h0000, 16'h0000, 16'h0033};
        vecs[7] = '{st(K_BR,  1, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0), 3, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'hFFFF};
        vecs[8] = '{st(K_NOP, 1, 16'h0123, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0), 3, 0, 16'h0000, 0, 0, 16'h0000, 16'h0000, 16'h0000};
        vecs[9] = '{st(K_SW,  0, 16'h0000, 16'h1234, 16'h0001, 16'h0000, 3'd5, 0), 4, 0, 16'h0000, 1, 1, 16'h1234, 16'h0001, 16'h0001};

        for (int i = 0; i < 256; i++) imem[i] = 16'($urandom);
        reset = 1'b1;
        set_dec(K_NOP);
        br_taken = 1'b0; br_target = '0; alu_c = '0; rd_data = '0;
        mem_gnt = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);

        // Reset state.
        check("rst.pc",        32'(pc),        32'h0);
        check("rst.imem_addr", 32'(imem_addr), 32'h0);
        check("rst.state",     32'(state),     32'(ST_FETCH));
        check("rst.instr",     32'(instr),     32'h0);
        check("rst.mem_req",   32'(mem_req),   32'h0);
        check("rst.mem_we",    32'(mem_we),    32'h0);
        check("rst.mem_addr",  32'(mem_addr),  32'h0);
        check("rst.reg_we",    32'(reg_we),    32'h0);
        check("rst.reg_wd",    32'(reg_wd),    32'h0);
        check("rst.halted",    32'(halted),    32'h0);
        reset = 1'b0;

        // Table-driven vectors.
        for (int i = 0; i < 10; i++) begin
            word = mkword(vecs[i].s.rd);
            run_instr(vecs[i].s, word, o);
            e = '{default: 0};
            e.cycles   = vecs[i].cycles;
            e.instr    = word;
            e.we_n     = vecs[i].we;
            e.ws       = (vecs[i].we != 0) ? vecs[i].s.rd : 3'd0;
            e.wd       = vecs[i].wd;
            e.we_cycle = (vecs[i].we != 0) ? vecs[i].cycles : 0;
            e.mem_n    = vecs[i].mem_n;
            e.mem_we   = vecs[i].mem_we;
            e.addr     = vecs[i].addr;
            e.wdata    = vecs[i].wdata;
            e.pc       = vecs[i].pc;
            cmp_obs($sformatf("vec%0d", i), o, e);
        end

        // Random instruction stream against the reference model.
        m_pc = vecs[9].pc;
        for (int i = 0; i < 200; i++) begin
            s = st(kind_t'($urandom_range(0, 4)), 1'($urandom), 16'($urandom), 16'($urandom),
                   16'($urandom), 16'($urandom), 3'($urandom), int'($urandom_range(0, 3)));
            word = mkword(s.rd);
            e = model(s, m_pc, word);
            run_instr(s, word, o);
            cmp_obs($sformatf("rnd%0d", i), o, e);
            m_pc = e.pc;
        end

        // Reset while a load waits for its grant.
        word = mkword(3'd4);
        imem[pc[7:0]] = word;
        set_dec(K_LW);
        alu_c = 16'h0040; rd_data = 16'h0000; mem_gnt = 1'b0;
        n = 0;
        while (state != ST_MEM && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstmem.in_mem",  32'(state),   32'(ST_MEM));
        check("rstmem.req_hi",  32'(mem_req), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        check("rstmem.mem_req", 32'(mem_req), 32'h0);
        check("rstmem.mem_we",  32'(mem_we),  32'h0);
        check("rstmem.state",   32'(state),   32'(ST_FETCH));
        check("rstmem.pc",      32'(pc),      32'h0);
        check("rstmem.reg_we",  32'(reg_we),  32'h0);
        reset = 1'b0;
        set_dec(K_NOP);
        s = st(K_NOP, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0);
        word = mkword(3'd0);
        e = model(s, 16'h0000, word);
        run_instr(s, word, o);
        cmp_obs("rstmem.after", o, e);

        // MOVI r1,5 then HALT from a fresh reset.
        apply_reset();
        s = st(K_ALU, 0, 16'h0000, 16'h0005, 16'h0000, 16'h0000, 3'd1, 0);
        word = mkword(3'd1);
        e = model(s, 16'h0000, word);
        run_instr(s, word, o);
        cmp_obs("movi", o, e);
        check("halt.pre", 32'(halted), 32'h0);
        s = st(K_HALT, 0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 3'd0, 0);
        word = mkword(3'd0);
        e = model(s, 16'h0001, word);
        run_instr(s, word, o);
        cmp_obs("halt", o, e);
        check("halt.cycle8", 32'(halted), 32'h1);
        check("halt.state",  32'(state),  32'(ST_HALT));
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            set_dec(kind_t'($urandom_range(0, 5)));
            mem_gnt = 1'($urandom);
            alu_c = 16'($urandom); br_taken = 1'b1; br_target = 16'($urandom);
            @(negedge clk);
            if (reg_we || mem_req || mem_we || !halted || state != ST_HALT) bad++;
        end
        check("halt.sticky", bad, 0);
        check("halt.pc",     32'(pc), 32'h0001);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
